// File: rtl/pos_dac_spi.sv
// rtl/pos_dac_spi.sv - clamps PID DAC codes and shifts them to the galvo DAC over SPI with LDAC update
module pos_dac_spi #(
    parameter int CLK_DIV     = 2,
    parameter int LDAC_WIDTH  = 2,
    parameter int AUTO_UPDATE = 0
) (
    input  logic        clk_pid_i,
    input  logic        sys_rst_i,
    input  logic [15:0] dac_code_i,
    input  logic        dac_code_valid_i,
    input  logic [15:0] dac_limit_i,
    output logic        dac_csn_o,
    output logic        dac_sclk_o,
    output logic        dac_mosi_o,
    output logic        dac_ldacn_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] last_code_o,
    output logic        clamp_hit_o,
    output logic [7:0]  overrun_cnt_o
);

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0]  LDAC_LAST = 8'(LDAC_WIDTH - 1);
    localparam logic [15:0] MID_CODE  = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CSH,
        ST_GAP,
        ST_LDAC
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  bit_cnt_q;
    logic [15:0] shreg_q;
    logic [15:0] cur_code_q;
    logic        csn_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        ldacn_q;
    logic        done_q;
    logic [15:0] last_code_q;
    logic        clamp_hit_q;
    logic [7:0]  overrun_q;
    logic        pend_full_q;
    logic [15:0] pend_code_q;
    logic        pend_clamp_q;
    logic [15:0] code_d1_q;
    logic        auto_stb_q;

    logic [16:0] hi_sum_d;
    logic [15:0] lo_d;
    logic [15:0] hi_d;
    logic [15:0] clamp_code_d;
    logic        clamp_flag_d;
    logic        strobe_d;
    logic        div_last_d;
    logic        fin_d;
    logic        launch_d;
    logic [15:0] launch_code_d;
    logic        launch_clamp_d;

    // Window is evaluated with the limit present on the capture edge; the
    // clamped code is what gets buffered, not the raw request.
    always_comb begin
        hi_sum_d = 17'd32768 + {1'b0, dac_limit_i};
        hi_d     = hi_sum_d[16] ? 16'hFFFF : hi_sum_d[15:0];
        lo_d     = (dac_limit_i > MID_CODE) ? 16'd0 : (MID_CODE - dac_limit_i);
        clamp_code_d = dac_code_i;
        clamp_flag_d = 1'b0;
        if (dac_code_i < lo_d) begin
            clamp_code_d = lo_d;
            clamp_flag_d = 1'b1;
        end else if (dac_code_i > hi_d) begin
            clamp_code_d = hi_d;
            clamp_flag_d = 1'b1;
        end
    end

    always_comb begin
        strobe_d       = dac_code_valid_i | auto_stb_q;
        div_last_d     = (cnt_q == DIV_LAST);
        fin_d          = (state_q == ST_LDAC) && (cnt_q == LDAC_LAST);
        launch_d       = ((state_q == ST_IDLE) || fin_d) && (strobe_d || pend_full_q);
        launch_code_d  = pend_full_q ? pend_code_q : clamp_code_d;
        launch_clamp_d = pend_full_q ? pend_clamp_q : clamp_flag_d;
    end

    always_ff @(posedge clk_pid_i) begin
        if (sys_rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            bit_cnt_q    <= 4'd0;
            shreg_q      <= 16'd0;
            cur_code_q   <= MID_CODE;
            csn_q        <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            ldacn_q      <= 1'b1;
            done_q       <= 1'b0;
            last_code_q  <= MID_CODE;
            clamp_hit_q  <= 1'b0;
            overrun_q    <= 8'd0;
            pend_full_q  <= 1'b0;
            pend_code_q  <= 16'd0;
            pend_clamp_q <= 1'b0;
            code_d1_q    <= dac_code_i;
            auto_stb_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            code_d1_q  <= dac_code_i;
            auto_stb_q <= (AUTO_UPDATE != 0) && (dac_code_i != code_d1_q);

            // Pending buffer: latest wins; refilling on the launch edge is not an overrun.
            if (launch_d) begin
                pend_full_q <= pend_full_q && strobe_d;
                if (pend_full_q && strobe_d) begin
                    pend_code_q  <= clamp_code_d;
                    pend_clamp_q <= clamp_flag_d;
                end
            end else if (strobe_d) begin
                pend_full_q  <= 1'b1;
                pend_code_q  <= clamp_code_d;
                pend_clamp_q <= clamp_flag_d;
                if (pend_full_q && (overrun_q != 8'hFF)) begin
                    overrun_q <= overrun_q + 8'd1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 8'd0;
                end
                ST_SHIFT: begin
                    if (div_last_d) begin
                        cnt_q  <= 8'd0;
                        sclk_q <= ~sclk_q;
                        if (sclk_q) begin
                            if (bit_cnt_q == 4'd15) begin
                                state_q <= ST_CSH;
                            end else begin
                                shreg_q   <= {shreg_q[14:0], 1'b0};
                                mosi_q    <= shreg_q[14];
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_CSH: begin
                    if (div_last_d) begin
                        cnt_q   <= 8'd0;
                        csn_q   <= 1'b1;
                        mosi_q  <= 1'b0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (div_last_d) begin
                        cnt_q   <= 8'd0;
                        ldacn_q <= 1'b0;
                        state_q <= ST_LDAC;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_LDAC: begin
                    if (fin_d) begin
                        cnt_q       <= 8'd0;
                        ldacn_q     <= 1'b1;
                        done_q      <= 1'b1;
                        last_code_q <= cur_code_q;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Launch overrides the case above so FIN can chain straight into SHIFT.
            if (launch_d) begin
                state_q     <= ST_SHIFT;
                cnt_q       <= 8'd0;
                bit_cnt_q   <= 4'd0;
                shreg_q     <= launch_code_d;
                cur_code_q  <= launch_code_d;
                csn_q       <= 1'b0;
                sclk_q      <= 1'b0;
                mosi_q      <= launch_code_d[15];
                clamp_hit_q <= launch_clamp_d;
            end
        end
    end

    assign dac_csn_o     = csn_q;
    assign dac_sclk_o    = sclk_q;
    assign dac_mosi_o    = mosi_q;
    assign dac_ldacn_o   = ldacn_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign last_code_o   = last_code_q;
    assign clamp_hit_o   = clamp_hit_q;
    assign overrun_cnt_o = overrun_q;

endmodule

// File: tb/tb_pos_dac_spi.sv
// tb/tb_pos_dac_spi.sv - scoreboard bench for pos_dac_spi with an SPI DAC model
module tb_pos_dac_spi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] code, limit;
    logic        valid;
    logic        csn, sclk, mosi, ldacn, busy, done, clamp;
    logic [15:0] last_code;
    logic [7:0]  ovr;

    logic [15:0] code2;
    logic        csn2, sclk2, mosi2, ldacn2, busy2, done2, clamp2;
    logic [15:0] last_code2;
    logic [7:0]  ovr2;

    pos_dac_spi #(.CLK_DIV(2), .LDAC_WIDTH(2), .AUTO_UPDATE(0)) dut (
        .clk_pid_i(clk), .sys_rst_i(rst), .dac_code_i(code), .dac_code_valid_i(valid),
        .dac_limit_i(limit), .dac_csn_o(csn), .dac_sclk_o(sclk), .dac_mosi_o(mosi),
        .dac_ldacn_o(ldacn), .busy_o(busy), .done_o(done), .last_code_o(last_code),
        .clamp_hit_o(clamp), .overrun_cnt_o(ovr)
    );

    pos_dac_spi #(.CLK_DIV(2), .LDAC_WIDTH(2), .AUTO_UPDATE(1)) dut_auto (
        .clk_pid_i(clk), .sys_rst_i(rst), .dac_code_i(code2), .dac_code_valid_i(1'b0),
        .dac_limit_i(16'd1000), .dac_csn_o(csn2), .dac_sclk_o(sclk2), .dac_mosi_o(mosi2),
        .dac_ldacn_o(ldacn2), .busy_o(busy2), .done_o(done2), .last_code_o(last_code2),
        .clamp_hit_o(clamp2), .overrun_cnt_o(ovr2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // DAC model: shifts on rising SCLK while selected, latches on LDAC fall
    logic [15:0] dac_sh = 16'h0000;
    logic [15:0] dac_val = 16'h8000;
    int dac_bits_run = 0;
    int dac_bits = 0;
    always @(posedge sclk) if (!csn) begin dac_sh = {dac_sh[14:0], mosi}; dac_bits_run++; end
    always @(negedge csn) dac_bits_run = 0;
    always @(negedge ldacn) begin dac_val = dac_sh; dac_bits = dac_bits_run; end

    typedef struct { logic clamp; int cyc; } launch_e;
    typedef struct { logic [15:0] code; int cyc; } done_e;
    launch_e launch_q[$];
    done_e   done_q[$];

    logic    csn_prev = 1'b1;
    launch_e le;
    done_e   de;
    always @(negedge clk) begin
        if (csn_prev && !csn) begin
            if (launch_q.size() == 0) chk("unexpected_launch", 1, 0);
            else begin
                le = launch_q.pop_front();
                chk("launch_edge", cyc, le.cyc);
                chk("clamp_hit", {31'd0, clamp}, {31'd0, le.clamp});
            end
        end
        csn_prev = csn;
        if (done) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                de = done_q.pop_front();
                chk("done_edge", cyc, de.cyc);
                chk("last_code", {16'd0, last_code}, {16'd0, de.code});
                chk("dac_model_code", {16'd0, dac_val}, {16'd0, de.code});
                chk("dac_model_bits", dac_bits, 16);
            end
        end
    end

    int done2_cnt = 0;
    always @(negedge clk) if (done2) done2_cnt++;

    task automatic at_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic strobe_at(input logic [15:0] c, input int e);
        while (cyc < e - 1) @(negedge clk);
        code  = c;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] c, input logic [15:0] exp_code, input logic exp_clamp,
                        output int t0);
        @(negedge clk);
        t0 = cyc + 1;
        launch_q.push_back('{exp_clamp, t0});
        done_q.push_back('{exp_code, t0 + 70});
        strobe_at(c, t0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin @(negedge clk); n++; end
        if (busy) chk("idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_csn"}, {31'd0, csn}, 1);
        chk({tag, "_sclk"}, {31'd0, sclk}, 0);
        chk({tag, "_mosi"}, {31'd0, mosi}, 0);
        chk({tag, "_ldacn"}, {31'd0, ldacn}, 1);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_last_code"}, {16'd0, last_code}, 32768);
        chk({tag, "_clamp"}, {31'd0, clamp}, 0);
        chk({tag, "_ovr"}, {24'd0, ovr}, 0);
    endtask

    initial begin
        int t0, k, ok;
        rst = 1'b1; valid = 1'b0; code = 16'h0000; limit = 16'd1000; code2 = 16'h8000;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal transfer with edge timing of CSN and LDAC
        send(16'h8123, 16'h8123, 1'b0, t0);
        at_edge(t0 + 65); chk("csn_low_65", {31'd0, csn}, 0);
        at_edge(t0 + 66); chk("csn_rise_66", {31'd0, csn}, 1);
        at_edge(t0 + 67); chk("ldacn_67", {31'd0, ldacn}, 1);
        at_edge(t0 + 68); chk("ldacn_68", {31'd0, ldacn}, 0);
        at_edge(t0 + 69); chk("ldacn_69", {31'd0, ldacn}, 0);
                          chk("busy_69", {31'd0, busy}, 1);
        wait_idle();

        // Clamp window
        send(16'd40000, 16'd33768, 1'b1, t0); wait_idle();
        send(16'd0, 16'd31768, 1'b1, t0); wait_idle();
        limit = 16'd40000;
        send(16'd0, 16'd0, 1'b0, t0); wait_idle();

        // A, B at +10, C at +20: B overwritten, C chains at the done edge
        @(negedge clk);
        t0 = cyc + 1;
        launch_q.push_back('{1'b0, t0});
        done_q.push_back('{16'h1111, t0 + 70});
        launch_q.push_back('{1'b0, t0 + 70});
        done_q.push_back('{16'h3333, t0 + 140});
        strobe_at(16'h1111, t0);
        ok = 1;
        fork
            strobe_at(16'h2222, t0 + 10);
            strobe_at(16'h3333, t0 + 20);
            for (int i = 0; i < 139; i++) begin
                if (!busy) ok = 0;
                @(negedge clk);
            end
        join
        chk("busy_overrun_run", ok, 1);
        chk("overrun_cnt", {24'd0, ovr}, 1);
        wait_idle();

        // Strobe exactly on the done edge with nothing pending
        @(negedge clk);
        t0 = cyc + 1;
        launch_q.push_back('{1'b0, t0});
        done_q.push_back('{16'h5555, t0 + 70});
        launch_q.push_back('{1'b0, t0 + 70});
        done_q.push_back('{16'h4444, t0 + 140});
        strobe_at(16'h5555, t0);
        ok = 1;
        fork
            strobe_at(16'h4444, t0 + 70);
            for (int i = 0; i < 139; i++) begin
                if (!busy) ok = 0;
                @(negedge clk);
            end
        join
        chk("busy_done_edge_run", ok, 1);
        chk("overrun_unchanged", {24'd0, ovr}, 1);
        wait_idle();

        // Reset at edge 30 of a transfer: no LDAC, DAC keeps 0x4444
        @(negedge clk);
        t0 = cyc + 1;
        launch_q.push_back('{1'b0, t0});
        strobe_at(16'h6789, t0);
        at_edge(t0 + 29);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        ok = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ldacn || done || busy) ok = 0;
        end
        chk("midrst_quiet", ok, 1);
        chk("midrst_dac_hold", {16'd0, dac_val}, 16'h4444);

        // Change detector instance
        @(negedge clk);
        k = cyc;
        code2 = 16'd33000;
        @(negedge clk); chk("auto_csn_k1", {31'd0, csn2}, 1);
        @(negedge clk); chk("auto_csn_k2", {31'd0, csn2}, 0);
        k = 0;
        while (done2_cnt == 0 && k < 200) begin @(negedge clk); k++; end
        chk("auto_done_cnt", done2_cnt, 1);
        chk("auto_last_code", {16'd0, last_code2}, 33000);
        ok = 1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy2 || !csn2) ok = 0;
        end
        chk("auto_no_retrigger", ok, 1);
        chk("auto_done_cnt_final", done2_cnt, 1);

        k = 0;
        while ((launch_q.size() != 0 || done_q.size() != 0) && k < 300) begin @(negedge clk); k++; end
        chk("launch_q_drained", launch_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
